// File: rtl/arbitro_vc.sv
// arbitro_vc: round-robin arbiter that drains four virtual-channel FIFOs
// into one destination FIFO, in bursts of up to blen_q+1 words per grant.
module arbitro_vc (
  input  logic       clk,
  input  logic       reset,
  input  logic       active_in,
  input  logic [3:0] fifo_empty,
  input  logic [5:0] data_in0,
  input  logic [5:0] data_in1,
  input  logic [5:0] data_in2,
  input  logic [5:0] data_in3,
  input  logic       dest_almost_full,
  input  logic [1:0] burst_len,
  output logic [3:0] fifo_pop,
  output logic [5:0] data_out,
  output logic       push_out,
  output logic [1:0] grant,
  output logic [1:0] state_out,
  output logic       idle_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SERVE = 2'b01,
    STALL = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] blen_q, blen_d;
  logic [5:0] data_q;
  logic       push_q;

  logic [1:0] pickIdx;
  logic       pickValid;
  logic       popEn;
  logic [5:0] headWord;

  // Round-robin pick: scan grant+1 .. grant+4; lower offsets overwrite, so the
  // nearest non-empty VC after the current grant wins and the current VC is last.
  always_comb begin
    pickIdx   = grant_q;
    pickValid = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      if (!fifo_empty[grant_q + 2'(k)]) begin
        pickIdx   = grant_q + 2'(k);
        pickValid = 1'b1;
      end
    end
  end

  // Head word of the granted VC, captured into data_out when it is popped.
  always_comb begin
    case (grant_q)
      2'd0:    headWord = data_in0;
      2'd1:    headWord = data_in1;
      2'd2:    headWord = data_in2;
      default: headWord = data_in3;
    endcase
  end

  // Next-state, burst bookkeeping and pop decision.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    blen_d  = blen_q;
    popEn   = 1'b0;
    case (state_q)
      IDLE: begin
        if (active_in && pickValid) begin
          state_d = SERVE;
          grant_d = pickIdx;
          cnt_d   = 2'd0;
          blen_d  = burst_len;
        end
      end
      SERVE: begin
        if (!active_in) begin
          state_d = IDLE;
        end else if (dest_almost_full) begin
          state_d = STALL;
        end else if (fifo_empty[grant_q]) begin
          if (pickValid) begin
            grant_d = pickIdx;
            cnt_d   = 2'd0;
            blen_d  = burst_len;
          end else begin
            state_d = IDLE;
          end
        end else begin
          popEn = 1'b1;
          if (cnt_q == blen_q) begin
            grant_d = pickIdx;
            cnt_d   = 2'd0;
            blen_d  = burst_len;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      STALL: begin
        if (!active_in) begin
          state_d = IDLE;
        end else if (!dest_almost_full) begin
          state_d = SERVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_pop = (popEn && !reset) ? (4'b0001 << grant_q) : 4'b0000;

  // State and output registers; data_out only moves when a word is pushed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 2'b11;
      cnt_q   <= 2'd0;
      blen_q  <= 2'd0;
      data_q  <= 6'd0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      blen_q  <= blen_d;
      push_q  <= |fifo_pop;
      if (|fifo_pop) begin
        data_q <= headWord;
      end
    end
  end

  assign data_out  = data_q;
  assign push_out  = push_q;
  assign grant     = grant_q;
  assign state_out = state_q;
  assign idle_out  = (state_q == IDLE);

endmodule

// File: tb/tb_arbitro_vc.sv
// tb_arbitro_vc: directed scenarios plus random traffic against a queue-based
// reference model; pushes are checked by a scoreboard monitor.
module tb_arbitro_vc;

  logic       clk;
  logic       reset;
  logic       active_in;
  logic [3:0] fifo_empty;
  logic [5:0] dataIn [4];
  logic       dest_almost_full;
  logic [1:0] burst_len;
  logic [3:0] fifo_pop;
  logic [5:0] data_out;
  logic       push_out;
  logic [1:0] grant;
  logic [1:0] state_out;
  logic       idle_out;

  typedef struct {
    logic [5:0] data;
    int         due;
  } expT;

  expT        expQ[$];
  logic [5:0] vcQ [4][$];
  int         popLog[$];
  int         testCount = 0;
  int         failCount = 0;
  int         edgeCount = 0;
  int         mState = 0;
  int         mGrant = 3;
  int         mLeft  = 1;
  logic [5:0] lastData = 6'd0;

  arbitro_vc dut (
    .clk              (clk),
    .reset            (reset),
    .active_in        (active_in),
    .fifo_empty       (fifo_empty),
    .data_in0         (dataIn[0]),
    .data_in1         (dataIn[1]),
    .data_in2         (dataIn[2]),
    .data_in3         (dataIn[3]),
    .dest_almost_full (dest_almost_full),
    .burst_len        (burst_len),
    .fifo_pop         (fifo_pop),
    .data_out         (data_out),
    .push_out         (push_out),
    .grant            (grant),
    .state_out        (state_out),
    .idle_out         (idle_out)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
    testCount++;
    if (act !== req) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int popIdx(input logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic bit anyWords();
    for (int v = 0; v < 4; v++) begin
      if (vcQ[v].size() != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Reference pick: nearest VC after the current grant that holds words.
  task automatic modelPick(input int bl);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (mGrant + k) % 4;
      if (vcQ[idx].size() != 0) begin
        mGrant = idx;
        mLeft  = bl + 1;
        return;
      end
    end
  endtask

  task automatic fillOne(input int v, input int n);
    for (int i = 0; i < n; i++) vcQ[v].push_back(6'($urandom));
  endtask

  task automatic fillAll(input int n);
    for (int v = 0; v < 4; v++) fillOne(v, n);
  endtask

  task automatic clearAll();
    for (int v = 0; v < 4; v++) vcQ[v].delete();
  endtask

  // One clock cycle: drive inputs, predict and check the pop, advance the
  // model, then check the registered state after the edge.
  task automatic applyStimulus(input bit rst, input bit act, input bit daf, input logic [1:0] bl);
    int         expPop;
    logic [3:0] expVec;
    @(negedge clk);
    reset            = rst;
    active_in        = act;
    dest_almost_full = daf;
    burst_len        = bl;
    for (int v = 0; v < 4; v++) begin
      fifo_empty[v] = (vcQ[v].size() == 0);
      dataIn[v]     = (vcQ[v].size() != 0) ? vcQ[v][0] : 6'($urandom);
    end
    #2;
    expPop = -1;
    if (rst) begin
      mState = 0;
      mGrant = 3;
      mLeft  = 1;
    end else begin
      case (mState)
        0: begin
          if (act && anyWords()) begin
            modelPick(int'(bl));
            mState = 1;
          end
        end
        1: begin
          if (!act) mState = 0;
          else if (daf) mState = 2;
          else if (vcQ[mGrant].size() == 0) begin
            if (anyWords()) modelPick(int'(bl));
            else mState = 0;
          end else begin
            expPop = mGrant;
            mLeft--;
            if (mLeft == 0) modelPick(int'(bl));
          end
        end
        default: begin
          if (!act) mState = 0;
          else if (!daf) mState = 1;
        end
      endcase
    end
    expVec = (expPop >= 0) ? (4'b0001 << expPop) : 4'b0000;
    checkOutput("fifo_pop", 8'(fifo_pop), 8'(expVec));
    popLog.push_back(popIdx(fifo_pop));
    if (expPop >= 0) begin
      expQ.push_back('{data: vcQ[expPop][0], due: edgeCount + 1});
      void'(vcQ[expPop].pop_front());
    end
    @(posedge clk);
    #1;
    checkOutput("state_out", 8'(state_out), 8'(mState));
    checkOutput("grant", 8'(grant), 8'(mGrant));
    checkOutput("idle_out", 8'(idle_out), 8'(mState == 0));
  endtask

  // Scoreboard monitor: every edge, a push must appear exactly when one is due.
  always @(posedge clk) begin
    logic rstS;
    logic expectPush;
    expT  e;
    rstS = reset;
    #1;
    edgeCount++;
    if (rstS) begin
      expQ.delete();
      checkOutput("rst_push", 8'(push_out), 8'd0);
      checkOutput("rst_data", 8'(data_out), 8'd0);
      lastData = 6'd0;
    end else begin
      expectPush = (expQ.size() > 0) && (expQ[0].due == edgeCount);
      checkOutput("push_out", 8'(push_out), 8'(expectPush));
      if (expectPush) begin
        e = expQ.pop_front();
        checkOutput("data_out", 8'(data_out), 8'(e.data));
        lastData = e.data;
      end else begin
        checkOutput("data_hold", 8'(data_out), 8'(lastData));
      end
    end
  end

  // Directed scenarios followed by random traffic.
  initial begin
    int exp30 [11] = '{-1, 0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    reset            = 1'b1;
    active_in        = 1'b0;
    dest_almost_full = 1'b0;
    burst_len        = 2'd0;
    fifo_empty       = 4'hF;
    for (int v = 0; v < 4; v++) dataIn[v] = 6'd0;

    // Reset held with traffic available.
    fillAll(3);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 2'd0);

    // Two-word bursts rotating over all four VCs.
    clearAll();
    fillAll(6);
    popLog.delete();
    repeat (11) applyStimulus(1'b0, 1'b1, 1'b0, 2'd1);
    for (int i = 0; i < 11; i++) checkOutput("rr_order", 8'(popLog[i]), 8'(exp30[i]));

    // Only VC2 with two words under a four-word burst.
    clearAll();
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
    fillOne(2, 2);
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 2'd3);
    checkOutput("vc2_drained_idle", 8'(idle_out), 8'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd3);

    // Destination almost full in the middle of a burst.
    clearAll();
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
    fillAll(6);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 2'd3);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 2'd3);
    checkOutput("stall_grant", 8'(grant), 8'd0);
    checkOutput("stall_state", 8'(state_out), 8'h2);
    repeat (6) applyStimulus(1'b0, 1'b1, 1'b0, 2'd3);

    // Enable dropped while serving, then while stalled.
    clearAll();
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
    fillAll(6);
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 2'd3);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd3);
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 2'd3);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd3);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd3);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd3);

    // Burst length changed after the pick, then a reset mid-burst.
    clearAll();
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0);
    fillAll(6);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0);
    repeat (7) applyStimulus(1'b0, 1'b1, 1'b0, 2'd3);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd3);
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 2'd3);

    // Random traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      for (int v = 0; v < 4; v++) begin
        if (vcQ[v].size() < 8 && $urandom_range(0, 2) == 0) fillOne(v, 1);
      end
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0,
                    $urandom_range(0, 3) == 0, 2'($urandom));
    end

    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0);
    checkOutput("scoreboard_empty", 8'(expQ.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
